// File: rtl/enigma_step_controller_pkg.sv
// Shared constants and state encoding for the Enigma key-press sequencer.
package enigma_step_controller_pkg;

  localparam int NUM_LETTERS = 26;
  localparam logic [4:0] LETTER_NONE = 5'd31;
  localparam int NOTCH0_DEFAULT = 16;
  localparam int NOTCH1_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SETTLE       = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/enigma_step_controller_rotor_position_counter.sv
// Modulo-N rotor position register with load, step and notch carry.
module rotor_position_counter
  import enigma_step_controller_pkg::*;
#(
  parameter int N = NUM_LETTERS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       inc,
  input  logic [4:0] notch,
  output logic [4:0] pos,
  output logic       carry
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= 5'd0;
    end else if (load) begin
      pos <= load_val;
    end else if (inc) begin
      pos <= (pos == 5'(N - 1)) ? 5'd0 : pos + 5'd1;
    end
  end

  assign carry = (pos == notch);

endmodule

// File: rtl/enigma_step_controller.sv
// One encipherment per key press: step rotors, settle, latch the lamp letter.
module enigma_step_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NOTCH0        = 16,
  parameter int NUM_LETTERS   = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [4:0]  key_letter,
  input  logic        set,
  input  logic        set_sel,
  input  logic [4:0]  set_state,
  input  logic [4:0]  lamp_in,
  output logic [4:0]  pos0,
  output logic [4:0]  pos1,
  output logic        step,
  output logic [4:0]  lamp_letter,
  output logic        lamp_valid,
  output logic        busy,
  output logic [15:0] press_count
);
  import enigma_step_controller_pkg::*;

  state_t     state;
  state_t     state_nx;
  logic       key_valid_q;
  logic [3:0] settle_cnt;
  logic       press_evt;
  logic       accept;
  logic       load0;
  logic       load1;
  logic       settle_done;
  logic       fast_carry;
  logic       slow_carry_unused;

  assign press_evt = key_valid & ~key_valid_q;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    load0       = 1'b0;
    load1       = 1'b0;
    settle_done = 1'b0;
    unique case (state)
      IDLE: begin
        // a load wins over a same-cycle press; that press is dropped
        if (set) begin
          if (set_state < 5'(NUM_LETTERS)) begin
            load0 = ~set_sel;
            load1 = set_sel;
          end
        end else if (press_evt &&
                     key_letter < 5'(NUM_LETTERS)) begin
          accept   = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd1) begin
          settle_done = 1'b1;
          state_nx    = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!key_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // key_valid_q resets high so a key held through reset is not a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_valid_q <= 1'b1;
      step        <= 1'b0;
      lamp_valid  <= 1'b0;
      lamp_letter <= LETTER_NONE;
      press_count <= 16'd0;
      settle_cnt  <= 4'd0;
    end else begin
      key_valid_q <= key_valid;
      step        <= accept;
      lamp_valid  <= settle_done;
      if (settle_done) lamp_letter <= lamp_in;
      if (accept) begin
        press_count <= press_count + 16'd1;
        settle_cnt  <= 4'(SETTLE_CYCLES);
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  rotor_position_counter #(.N(NUM_LETTERS)) u_fast (
    .clock    (clock),
    .reset    (reset),
    .load     (load0),
    .load_val (set_state),
    .inc      (accept),
    .notch    (5'(NOTCH0)),
    .pos      (pos0),
    .carry    (fast_carry)
  );

  rotor_position_counter #(.N(NUM_LETTERS)) u_slow (
    .clock    (clock),
    .reset    (reset),
    .load     (load1),
    .load_val (set_state),
    .inc      (accept & fast_carry),
    .notch    (5'(NOTCH1_DEFAULT)),
    .pos      (pos1),
    .carry    (slow_carry_unused)
  );

endmodule
